fft_pwr_avg: RTL and testbench

//  Downstream consumer of the FFT output stream (natural-order bins, vld/new_fft framing).

---
 rtl/fft_pwr_avg.sv | 176 +++++++++++++++++
 tb/tb_fft_pwr_avg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_pwr_avg.sv
// Per-bin power |X|^2 of a natural-order FFT stream, averaged over 2^AVG_LOG2 frames
// through a FFT_LEN-deep read-modify-write accumulator RAM, with a sticky clip flag.
module fft_pwr_avg #(
  parameter int IN_W     = 28,
  parameter int FFT_LEN  = 256,
  parameter int AVG_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       i_init,
  input  logic                       i_vld,
  input  logic                       i_new_fft,
  input  logic signed [IN_W-1:0]     i_I,
  input  logic signed [IN_W-1:0]     i_Q,
  input  logic                       i_clip_strb,
  output logic                       o_vld,
  output logic                       o_new_avg,
  output logic [$clog2(FFT_LEN)-1:0] o_bin,
  output logic [2*IN_W-1:0]          o_pwr,
  output logic                       o_clip,
  output logic                       o_sync_err
);
  localparam int PWR_W = 2 * IN_W;
  localparam int ACC_W = PWR_W + AVG_LOG2;
  localparam int BIN_W = $clog2(FFT_LEN);
  localparam int FRM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'((1 << AVG_LOG2) - 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
  localparam logic [ACC_W-1:0] RND =
    (AVG_LOG2 > 0) ? ACC_W'(1) << ((AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0) : '0;

  typedef enum logic {SYNC = 1'b0, ACCUM = 1'b1} state_t;
  state_t state_q, state_d;

  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             clip_sticky_q, clip_sticky_d;

  logic             s0_vld, s0_resync;
  logic [BIN_W-1:0] s0_bin;
  logic [FRM_W-1:0] s0_frm;

  logic signed [PWR_W-1:0] i_ext, q_ext, isq1_d, qsq1_d;
  logic             vld1_q, vld2_q;
  logic [BIN_W-1:0] bin1_q, bin2_q;
  logic [FRM_W-1:0] frm1_q, frm2_q;
  logic [PWR_W-1:0] isq1_q, qsq1_q, pwr2_d, pwr2_q;
  logic [ACC_W-1:0] ram_rd_q, acc2_q, acc_base, sum, sum_rnd;
  logic             wr_en, out_vld;

  logic             o_vld_d, o_vld_q, o_new_avg_d, o_new_avg_q;
  logic             o_clip_d, o_clip_q, o_sync_err_d, o_sync_err_q;
  logic [BIN_W-1:0] o_bin_d, o_bin_q;
  logic [PWR_W-1:0] o_pwr_d, o_pwr_q;

  logic [ACC_W-1:0] mem [FFT_LEN];

  // Stage 0: frame tracking assigns each accepted sample its bin and frame.
  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    frm_cnt_d = frm_cnt_q;
    s0_vld    = 1'b0;
    s0_resync = 1'b0;
    s0_bin    = bin_cnt_q;
    s0_frm    = frm_cnt_q;
    if (i_vld) begin
      if (state_q == SYNC) begin
        if (i_new_fft) begin
          state_d   = ACCUM;
          s0_vld    = 1'b1;
          s0_bin    = '0;
          s0_frm    = '0;
          bin_cnt_d = BIN_W'(1);
          frm_cnt_d = '0;
        end
      end else if (i_new_fft && (bin_cnt_q != '0)) begin
        s0_vld    = 1'b1;
        s0_resync = 1'b1;
        s0_bin    = '0;
        s0_frm    = '0;
        bin_cnt_d = BIN_W'(1);
        frm_cnt_d = '0;
      end else begin
        s0_vld    = 1'b1;
        bin_cnt_d = bin_cnt_q + 1'b1;
        if (bin_cnt_q == LAST_BIN)
          frm_cnt_d = (frm_cnt_q == LAST_FRM) ? '0 : frm_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    i_ext  = PWR_W'(i_I);
    q_ext  = PWR_W'(i_Q);
    isq1_d = i_ext * i_ext;
    qsq1_d = q_ext * q_ext;
    pwr2_d = isq1_q + qsq1_q;
  end

  // Stage 3: frame 0 ignores the stale RAM word, so the RAM never needs clearing.
  always_comb begin
    acc_base = (frm2_q == '0) ? '0 : acc2_q;
    sum      = acc_base + ACC_W'(pwr2_q);
    sum_rnd  = sum + RND;
    out_vld  = vld2_q && (frm2_q == LAST_FRM);
    wr_en    = vld2_q && (frm2_q != LAST_FRM);

    o_vld_d      = out_vld;
    o_new_avg_d  = out_vld && (bin2_q == '0);
    o_bin_d      = out_vld ? bin2_q : '0;
    o_pwr_d      = out_vld ? PWR_W'(sum_rnd >> AVG_LOG2) : '0;
    o_clip_d     = out_vld && (clip_sticky_q || i_clip_strb);
    o_sync_err_d = s0_resync;

    // A strobe coinciding with the window's final output is reported there, then cleared.
    clip_sticky_d = clip_sticky_q;
    if (s0_resync || (out_vld && (bin2_q == LAST_BIN)))
      clip_sticky_d = 1'b0;
    else if ((state_q == ACCUM) && i_clip_strb)
      clip_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_init) begin
      state_q       <= SYNC;
      bin_cnt_q     <= '0;
      frm_cnt_q     <= '0;
      clip_sticky_q <= 1'b0;
      vld1_q        <= 1'b0;
      vld2_q        <= 1'b0;
      o_vld_q       <= 1'b0;
      o_new_avg_q   <= 1'b0;
      o_bin_q       <= '0;
      o_pwr_q       <= '0;
      o_clip_q      <= 1'b0;
      o_sync_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bin_cnt_q     <= bin_cnt_d;
      frm_cnt_q     <= frm_cnt_d;
      clip_sticky_q <= clip_sticky_d;
      vld1_q        <= s0_vld;
      vld2_q        <= vld1_q;
      o_vld_q       <= o_vld_d;
      o_new_avg_q   <= o_new_avg_d;
      o_bin_q       <= o_bin_d;
      o_pwr_q       <= o_pwr_d;
      o_clip_q      <= o_clip_d;
      o_sync_err_q  <= o_sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    bin1_q <= s0_bin;
    frm1_q <= s0_frm;
    isq1_q <= isq1_d;
    qsq1_q <= qsq1_d;
    bin2_q <= bin1_q;
    frm2_q <= frm1_q;
    pwr2_q <= pwr2_d;
    acc2_q <= ram_rd_q;
  end

  // Same-bin accesses are at least FFT_LEN samples apart, so no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (wr_en) mem[bin2_q] <= sum;
    ram_rd_q <= mem[s0_bin];
  end

  assign o_vld      = o_vld_q;
  assign o_new_avg  = o_new_avg_q;
  assign o_bin      = o_bin_q;
  assign o_pwr      = o_pwr_q;
  assign o_clip     = o_clip_q;
  assign o_sync_err = o_sync_err_q;
endmodule

// File: tb/tb_fft_pwr_avg.sv
// Bench for fft_pwr_avg: directed window table, resync sequence and randomized
// traffic, all checked cycle by cycle against a frame-level reference model.
module tb_fft_pwr_avg;
  localparam int IN_W  = 8;
  localparam int LEN   = 8;
  localparam int A     = 2;
  localparam int NFRM  = 1 << A;
  localparam int PWR_W = 2 * IN_W;
  localparam int BIN_W = $clog2(LEN);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   i_init = 1'b1, i_vld = 1'b0, i_new_fft = 1'b0, i_clip_strb = 1'b0;
  logic signed [IN_W-1:0] i_I = '0, i_Q = '0;
  logic                   o_vld, o_new_avg, o_clip, o_sync_err;
  logic [BIN_W-1:0]       o_bin;
  logic [PWR_W-1:0]       o_pwr;

  fft_pwr_avg #(.IN_W(IN_W), .FFT_LEN(LEN), .AVG_LOG2(A)) dut (
    .clk(clk), .i_init(i_init), .i_vld(i_vld), .i_new_fft(i_new_fft),
    .i_I(i_I), .i_Q(i_Q), .i_clip_strb(i_clip_strb),
    .o_vld(o_vld), .o_new_avg(o_new_avg), .o_bin(o_bin), .o_pwr(o_pwr),
    .o_clip(o_clip), .o_sync_err(o_sync_err)
  );

  typedef struct {int due; int bin; longint pwr; bit clip;} exp_t;
  typedef struct {int cyc; int bin; longint pwr; bit clip; bit new_avg;} obs_t;
  typedef struct {int i[4]; int q[4]; int clip_frm; longint exp_pwr; bit exp_clip;} vec_t;

  exp_t   pend[$];
  obs_t   cap[$];
  vec_t   tbl[8];
  int     n_tests = 0, n_fail = 0;
  int     cyc = 0, sync_due = -1, sync_cnt = 0;
  bit     m_run = 0, m_sticky = 0;
  int     m_bin = 0, m_frm = 0;
  longint m_acc[LEN];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit   ev;
    exp_t e;
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (o_vld) cap.push_back('{cyc, int'(o_bin), longint'(o_pwr), o_clip, o_new_avg});
    if (o_sync_err) sync_cnt++;
    chk("o_vld", o_vld, ev);
    if (ev) begin
      e = pend.pop_front();
      chk("o_bin", o_bin, e.bin);
      chk("o_pwr", o_pwr, e.pwr);
      chk("o_new_avg", o_new_avg, e.bin == 0);
      chk("o_clip", o_clip, e.clip);
    end else begin
      chk("o_new_avg_idle", o_new_avg, 0);
      chk("o_clip_idle", o_clip, 0);
    end
    chk("o_sync_err", o_sync_err, sync_due == cyc);
  endtask

  // Frame-level model: accumulate power per bin, emit the rounded mean on the last frame.
  task automatic take(input int b, input int f, input int ii, input int qq);
    longint p;
    p = longint'(ii * ii + qq * qq);
    if (f == 0) m_acc[b] = p;
    else        m_acc[b] += p;
    if (f == NFRM - 1)
      pend.push_back('{cyc + 3, b, (m_acc[b] + (1 << (A - 1))) >> A, 1'b0});
  endtask

  task automatic model_step(input bit init, input bit vld, input bit nf,
                            input int ii, input int qq, input bit clip);
    bit run_before, clr, rs;
    if (init) begin
      m_run = 0; m_bin = 0; m_frm = 0; m_sticky = 0;
      pend.delete();
      sync_due = -1;
      return;
    end
    run_before = m_run; clr = 0; rs = 0;
    foreach (pend[k])
      if (pend[k].due == cyc + 1) begin
        pend[k].clip = m_sticky | clip;
        if (pend[k].bin == LEN - 1) clr = 1;
      end
    if (vld) begin
      if (!m_run) begin
        if (nf) begin m_run = 1; take(0, 0, ii, qq); m_bin = 1; m_frm = 0; end
      end else if (nf && m_bin != 0) begin
        rs = 1; sync_due = cyc + 1;
        take(0, 0, ii, qq); m_bin = 1; m_frm = 0;
      end else begin
        take(m_bin, m_frm, ii, qq);
        m_bin++;
        if (m_bin == LEN) begin m_bin = 0; m_frm = (m_frm + 1) % NFRM; end
      end
    end
    if (rs || clr) m_sticky = 0;
    else if (run_before && clip) m_sticky = 1;
  endtask

  task automatic step(input bit init, input bit vld, input bit nf,
                      input int ii, input int qq, input bit clip);
    @(negedge clk);
    check_outputs();
    i_init = init; i_vld = vld; i_new_fft = nf;
    i_I = IN_W'(ii); i_Q = IN_W'(qq); i_clip_strb = clip;
    model_step(init, vld, nf, ii, qq, clip);
    cyc++;
  endtask

  function automatic vec_t mk(int i0, int i1, int i2, int i3, int q0, int q1, int q2, int q3,
                              int cf, longint ep, bit ec);
    vec_t v;
    v.i[0] = i0; v.i[1] = i1; v.i[2] = i2; v.i[3] = i3;
    v.q[0] = q0; v.q[1] = q1; v.q[2] = q2; v.q[3] = q3;
    v.clip_frm = cf; v.exp_pwr = ep; v.exp_clip = ec;
    return v;
  endfunction

  initial begin
    int f3b0, rcin, gbin;
    obs_t o;
    bit vld, nf, ini;

    tbl[0] = mk(3, 3, 3, 3, 4, 4, 4, 4, -1, 25, 0);
    tbl[1] = mk(1, 1, 0, 1, 0, 0, 1, 1, 2, 1, 1);          // powers 1,1,1,2
    tbl[2] = mk(1, 1, 1, 0, 1, 1, 1, 0, -1, 2, 0);         // powers 2,2,2,0
    tbl[3] = mk(-128, -128, -128, -128, -128, -128, -128, -128, -1, 32768, 0);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    tbl[5] = mk(127, 127, 127, 127, -128, -128, -128, -128, -1, 32513, 0);
    tbl[6] = mk(0, 0, 0, 1, 0, 0, 0, 0, -1, 0, 0);         // mean 0.25 rounds down
    tbl[7] = mk(0, 0, 1, 1, 0, 0, 0, 0, -1, 1, 0);         // mean 0.5 rounds up
    f3b0 = 0;

    repeat (3) step(1, 0, 0, 0, 0, 0);
    foreach (tbl[k])
      for (int f = 0; f < NFRM; f++)
        for (int b = 0; b < LEN; b++) begin
          if (k == 0 && f == NFRM - 1 && b == 0) f3b0 = cyc;
          step(0, 1, b == 0, tbl[k].i[f], tbl[k].q[f], (tbl[k].clip_frm == f) && (b == 2));
        end
    repeat (12) step(0, 0, 0, 0, 0, 0);
    chk("tbl_count", cap.size(), 8 * LEN);
    if (cap.size() == 8 * LEN) begin
      foreach (tbl[k])
        for (int b = 0; b < LEN; b++) begin
          o = cap[k * LEN + b];
          chk("tbl_bin", o.bin, b);
          chk("tbl_pwr", o.pwr, tbl[k].exp_pwr);
          chk("tbl_new_avg", o.new_avg, b == 0);
          chk("tbl_clip", o.clip, tbl[k].exp_clip);
        end
      chk("first_out_latency", cap[0].cyc - f3b0, 3);
    end

    // Resync at bin 3 of frame 1: partial window discarded, averages restart there.
    cap.delete(); sync_cnt = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < LEN; b++) step(0, 1, b == 0, 7, 7, 0);
    for (int b = 0; b < 3; b++) step(0, 1, b == 0, 7, 7, 0);
    rcin = cyc;
    step(0, 1, 1, 5, 0, 0);
    for (int s = 1; s < NFRM * LEN; s++) step(0, 1, (s % LEN) == 0, 5, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    chk("resync_err_pulses", sync_cnt, 1);
    chk("resync_count", cap.size(), LEN);
    if (cap.size() == LEN) begin
      foreach (cap[k]) begin
        chk("resync_bin", cap[k].bin, k);
        chk("resync_pwr", cap[k].pwr, 25);
      end
      chk("resync_latency", cap[0].cyc - rcin, (NFRM - 1) * LEN + 3);
    end

    // Random bubbles, data, clip strobes, occasional resyncs and one mid-frame init.
    cap.delete();
    repeat (2) step(1, 0, 0, 0, 0, 0);
    gbin = 3;
    for (int c = 0; c < 1500; c++) begin
      ini = (c == 700);
      vld = $urandom_range(0, 1) == 1;
      nf  = $urandom_range(0, 1) == 1;
      if (ini) gbin = 3;
      else if (vld) begin
        if (gbin != 0 && $urandom_range(0, 199) == 0) begin
          nf = 1; gbin = 1;
        end else begin
          nf = (gbin == 0); gbin = (gbin + 1) % LEN;
        end
      end
      step(ini, vld, nf, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 49) == 0);
    end
    repeat (10) step(0, 0, 0, 0, 0, 0);
    chk("rand_outputs_seen", cap.size() > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
